mult_div_unit: RTL

- Iterative multiply/divide unit for the MIPS datapath. Owns the HI/LO special registers.
- Sits directly downstream of the register bank. Operands come from the bank's two read ports (rs on port 1, rt on port 2).
- Executes MULT, MULTU, DIV and DIVU over multiple cycles. Exposes HI/LO for MFHI/MFLO writeback into the register bank.
- Supports MTHI/MTLO direct writes.

---
 rtl/mult_div_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO special registers.
// Latency: start sampled at E0, hi/lo written and done high in the cycle after edge E(WIDTH+2).
// Backpressure: start is accepted only in IDLE with done low; start/mthi/mtlo are ignored otherwise.
// Ports: clk, rst_n (async, active low); start/op/rs_val/rt_val request an operation;
//        mthi/mtlo write rs_val into HI/LO when idle; hi/lo are the registers;
//        busy marks an operation in flight; done pulses for one cycle per result.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     m_q, m_d;          // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d; // product upper half / partial remainder
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d; // multiplier bits / dividend-then-quotient
  logic               div_q, div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_a_q, neg_a_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand magnitudes are WIDTH+1 bits so the most-negative value negates cleanly.
  logic               a_neg, b_neg;
  logic [WIDTH:0]     a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     r_sh;
  logic [2*WIDTH-1:0] prod;

  assign a_neg = ~op[0] & rs_val[WIDTH-1];
  assign b_neg = ~op[0] & rt_val[WIDTH-1];
  assign a_mag = a_neg ? ({1'b0, ~rs_val} + (WIDTH+1)'(1)) : {1'b0, rs_val};
  assign b_mag = b_neg ? ({1'b0, ~rt_val} + (WIDTH+1)'(1)) : {1'b0, rt_val};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_a_d   = neg_a_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    sum       = '0;
    r_sh      = '0;
    prod      = '0;

    case (state_q)
      IDLE: begin
        if (!done_q) begin
          if (start) begin
            div_d     = op[1];
            neg_res_d = a_neg ^ b_neg;
            neg_a_d   = a_neg;
            div0_d    = (rt_val == '0);
            m_d       = op[1] ? b_mag : a_mag;
            acc_lo_d  = op[1] ? a_mag[WIDTH-1:0] : b_mag[WIDTH-1:0];
            acc_hi_d  = '0;
            cnt_d     = CW'(WIDTH);
            state_d   = CALC;
          end else begin
            if (mthi) hi_d = rs_val;
            if (mtlo) lo_d = rs_val;
          end
        end
      end

      CALC: begin
        if (div_q) begin
          // Restoring step: shift in next dividend bit, subtract divisor if it fits.
          r_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
          if (r_sh >= m_q) begin
            acc_hi_d = WIDTH'(r_sh - m_q);
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = r_sh[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          // Shift-add step: the carry out of the add shifts down into the upper half.
          sum      = {1'b0, acc_hi_q} + (acc_lo_q[0] ? m_q : '0);
          acc_hi_d = sum[WIDTH:1];
          acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end

      FIX: begin
        if (div_q) begin
          // A zero divisor keeps the all-ones quotient; the remainder then equals rs.
          if (neg_res_q && !div0_q) acc_lo_d = -acc_lo_q;
          if (neg_a_q)              acc_hi_d = -acc_hi_q;
        end else begin
          prod = {acc_hi_q, acc_lo_q};
          if (neg_res_q) prod = -prod;
          acc_hi_d = prod[2*WIDTH-1:WIDTH];
          acc_lo_d = prod[WIDTH-1:0];
        end
        state_d = DONE;
      end

      DONE: begin
        hi_d    = acc_hi_q;
        lo_d    = acc_lo_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      m_q       <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_a_q   <= neg_a_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule
